multi_counter: RTL and testbench

MULTI_COUNTER -- requirements
Module: multi_counter

---
 rtl/multi_counter_pkg.sv | 11 +
 rtl/clk_prescaler.sv | 37 +++
 rtl/multi_counter.sv | 88 ++++++++
 tb/tb_multi_counter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_counter_pkg.sv
// Shared constants for the multi-channel counter: per-channel mode field
// width and mode encodings (the fourth encoding behaves as WRAP).
package multi_counter_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_WRAP    = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b01;
    localparam logic [MODE_W-1:0] MODE_FREE    = 2'b10;

endpackage

// File: rtl/clk_prescaler.sv
// Shared prescaler: a registered tick once per divide period, where a divider
// of 0 or 1 both mean divide-by-1.
module clk_prescaler #(
    parameter int DIVIDER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIVIDER_WIDTH-1:0] divider,
    output logic                     tick
);

    logic [DIVIDER_WIDTH-1:0] r_pc;
    logic                     r_tick;
    logic [DIVIDER_WIDTH-1:0] w_last_pc;
    logic                     w_wrap;

    // Compare with >= so that lowering the divider below the current phase
    // wraps immediately instead of running the count all the way around.
    assign w_last_pc = (divider <= DIVIDER_WIDTH'(1)) ? '0 : divider - DIVIDER_WIDTH'(1);
    assign w_wrap    = (r_pc >= w_last_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc   <= '0;
            r_tick <= 1'b0;
        end else if (w_wrap) begin
            r_pc   <= '0;
            r_tick <= 1'b1;
        end else begin
            r_pc   <= r_pc + DIVIDER_WIDTH'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/multi_counter.sv
// NCH independent counters stepped by a shared prescaler tick, each with its
// own WRAP / ONESHOT / FREE terminal behaviour and match/done reporting.
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter int NCH           = 2,
    parameter int WIDTH         = 16,
    parameter int DIVIDER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIVIDER_WIDTH-1:0] divider,
    input  logic [NCH-1:0]           inc,
    input  logic [NCH-1:0]           clear,
    input  logic [MODE_W*NCH-1:0]    mode,
    input  logic [WIDTH*NCH-1:0]     compare,
    input  logic [WIDTH*NCH-1:0]     init_val,
    output logic [WIDTH*NCH-1:0]     counter,
    output logic                     tick,
    output logic [NCH-1:0]           early_match,
    output logic [NCH-1:0]           match,
    output logic [NCH-1:0]           done
);

    logic w_tick;

    clk_prescaler #(
        .DIVIDER_WIDTH(DIVIDER_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .divider(divider),
        .tick   (w_tick)
    );

    assign tick = w_tick;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [WIDTH-1:0]  r_count;
        logic              r_match;
        logic              r_done;
        logic [MODE_W-1:0] w_mode;
        logic [WIDTH-1:0]  w_cmp;
        logic [WIDTH-1:0]  w_init;
        logic              w_step;
        logic              w_term;
        logic              w_early;

        assign w_mode = mode[MODE_W*gi +: MODE_W];
        assign w_cmp  = compare[WIDTH*gi +: WIDTH];
        assign w_init = init_val[WIDTH*gi +: WIDTH];

        // FREE ignores compare and terminates on the all-ones count.
        assign w_term  = (w_mode == MODE_FREE) ? (r_count == '1) : (r_count == w_cmp);
        assign w_step  = inc[gi] & w_tick & ~r_done;
        assign w_early = w_step & w_term & ~clear[gi];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_count <= '0;
                r_match <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                r_match <= w_early;
                if (clear[gi]) begin
                    r_count <= w_init;
                    r_done  <= 1'b0;
                end else if (w_step) begin
                    if (w_term) begin
                        case (w_mode)
                            MODE_ONESHOT: r_done  <= 1'b1;
                            MODE_FREE:    r_count <= '0;
                            default:      r_count <= w_init;
                        endcase
                    end else begin
                        r_count <= r_count + WIDTH'(1);
                    end
                end
            end
        end

        assign counter[WIDTH*gi +: WIDTH] = r_count;
        assign early_match[gi]            = w_early;
        assign match[gi]                  = r_match;
        assign done[gi]                   = r_done;
    end

endmodule

// File: tb/tb_multi_counter.sv
// Self-checking bench for multi_counter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_multi_counter;

    localparam int NCH  = 3;
    localparam int W    = 4;
    localparam int DW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     divider;
    logic [NCH-1:0]    inc, clear;
    logic [2*NCH-1:0]  mode;
    logic [W*NCH-1:0]  compare, init_val;
    logic [W*NCH-1:0]  counter;
    logic              tick;
    logic [NCH-1:0]    early_match, match, done;

    multi_counter #(.NCH(NCH), .WIDTH(W), .DIVIDER_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .divider(divider), .inc(inc), .clear(clear),
        .mode(mode), .compare(compare), .init_val(init_val), .counter(counter),
        .tick(tick), .early_match(early_match), .match(match), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_cnt  [NCH];
    bit m_done [NCH];
    bit m_match[NCH];
    int m_pc;
    bit m_tick;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_cnt(input int ch);
        return int'(counter[W*ch +: W]);
    endfunction

    task automatic set_ch(input int ch, input int md, input int cmp, input int ini);
        mode[2*ch +: 2]      = 2'(md);
        compare[W*ch +: W]   = W'(cmp);
        init_val[W*ch +: W]  = W'(ini);
    endtask

    function automatic bit m_term(input int ch);
        int md = int'(mode[2*ch +: 2]);
        if (md == 2) return m_cnt[ch] == MAXV;
        return m_cnt[ch] == int'(compare[W*ch +: W]);
    endfunction

    function automatic bit m_em(input int ch);
        return inc[ch] && m_tick && !m_done[ch] && m_term(ch) && !clear[ch];
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_done[c] = 0; m_match[c] = 0;
        end
        m_pc = 0; m_tick = 0;
    endtask

    task automatic model_step();
        int d = (divider == 0) ? 1 : int'(divider);
        for (int c = 0; c < NCH; c++) begin
            bit stp  = inc[c] && m_tick && !m_done[c];
            bit trm  = m_term(c);
            int md   = int'(mode[2*c +: 2]);
            m_match[c] = m_em(c);
            if (clear[c]) begin
                m_cnt[c]  = int'(init_val[W*c +: W]);
                m_done[c] = 0;
            end else if (stp) begin
                if (!trm)         m_cnt[c] = (m_cnt[c] + 1) % (MAXV + 1);
                else if (md == 1) m_done[c] = 1;
                else if (md == 2) m_cnt[c] = 0;
                else              m_cnt[c] = int'(init_val[W*c +: W]);
            end
        end
        if (m_pc >= d - 1) begin m_pc = 0; m_tick = 1; end
        else begin m_pc++; m_tick = 0; end
    endtask

    task automatic compare_all();
        chk("tick", int'(tick), int'(m_tick));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("counter[%0d]", c), dut_cnt(c), m_cnt[c]);
            chk($sformatf("match[%0d]", c), int'(match[c]), int'(m_match[c]));
            chk($sformatf("done[%0d]", c), int'(done[c]), int'(m_done[c]));
            chk($sformatf("early_match[%0d]", c), int'(early_match[c]), int'(m_em(c)));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        int ticks;
        bit seen;
        reset = 1'b1; divider = '0; inc = '0; clear = '0;
        mode = '0; compare = '0; init_val = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset counter", int'(counter), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset match", int'(match), 0);
        chk("reset done", int'(done), 0);
        compare_all();
        reset = 1'b0;

        // WRAP, divider 0, compare 3: 0,1,2,3,0
        set_ch(0, 0, 3, 0);
        clear = 3'b001; cyc();
        chk("wrap start", dut_cnt(0), 0);
        clear = '0; inc = 3'b001;
        cyc(); chk("wrap c1", dut_cnt(0), 1);
        cyc(); chk("wrap c2", dut_cnt(0), 2);
        cyc(); chk("wrap c3", dut_cnt(0), 3);
        chk("wrap early", int'(early_match[0]), 1);
        chk("wrap no match yet", int'(match[0]), 0);
        cyc(); chk("wrap c0", dut_cnt(0), 0);
        chk("wrap match", int'(match[0]), 1);
        chk("wrap early off", int'(early_match[0]), 0);
        inc = '0;

        // ONESHOT init 5 compare 7, divider 1
        divider = 4'd1;
        set_ch(1, 1, 7, 5);
        clear = 3'b010; cyc();
        chk("oneshot init", dut_cnt(1), 5);
        clear = '0; inc = 3'b010;
        cyc(); chk("oneshot 6", dut_cnt(1), 6);
        cyc(); chk("oneshot 7", dut_cnt(1), 7);
        cyc(); chk("oneshot hold", dut_cnt(1), 7);
        chk("oneshot done", int'(done[1]), 1);
        chk("oneshot match", int'(match[1]), 1);
        cyc(); chk("oneshot still 7", dut_cnt(1), 7);
        chk("oneshot single pulse", int'(match[1]), 0);
        inc = '0; clear = 3'b010; cyc();
        chk("oneshot clear cnt", dut_cnt(1), 5);
        chk("oneshot clear done", int'(done[1]), 0);
        clear = '0;

        // FREE init 14, compare ignored
        set_ch(2, 2, 3, 14);
        clear = 3'b100; cyc();
        clear = '0; inc = 3'b100;
        chk("free 14", dut_cnt(2), 14);
        cyc(); chk("free 15", dut_cnt(2), 15);
        cyc(); chk("free 0", dut_cnt(2), 0);
        chk("free match", int'(match[2]), 1);
        inc = '0;

        // clear and inc together on a terminal cycle
        set_ch(0, 0, 3, 3);
        clear = 3'b001; cyc();
        set_ch(0, 0, 3, 1);
        clear = 3'b001; inc = 3'b001; #1;
        chk("clr+inc early", int'(early_match[0]), 0);
        cyc(); chk("clr+inc cnt", dut_cnt(0), 1);
        chk("clr+inc match", int'(match[0]), 0);
        clear = '0; inc = '0;

        // divider 4: one tick per 4 cycles, then lowered to 2 mid-period
        divider = 4'd4; inc = 3'b001; ticks = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(); ticks += int'(tick);
        end
        chk("div4 tick count", ticks, 3);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc(); seen = tick;
        end
        chk("div4 tick seen", int'(seen), 1);
        cyc(); chk("div4 phase1", int'(tick), 0);
        divider = 4'd2;
        cyc(); chk("div lowered tick", int'(tick), 1);
        cyc(); chk("div2 off", int'(tick), 0);
        cyc(); chk("div2 on", int'(tick), 1);

        // reset mid-count with divider 3
        divider = 4'd3; inc = 3'b111;
        repeat (5) cyc();
        reset = 1'b1; #1;
        chk("midreset counter", int'(counter), 0);
        chk("midreset tick", int'(tick), 0);
        chk("midreset match", int'(match), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset early", int'(early_match), 0);
        m_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(); chk("post-reset t1", int'(tick), 0);
        cyc(); chk("post-reset t2", int'(tick), 0);
        cyc(); chk("post-reset t3", int'(tick), 1);

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) divider = DW'($urandom_range(0, 4));
            inc = NCH'($urandom);
            for (int c = 0; c < NCH; c++) begin
                clear[c] = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 40) == 0)
                    set_ch(c, $urandom_range(0, 3), $urandom_range(0, MAXV), $urandom_range(0, MAXV));
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
